// File: rtl/mac_pkg.sv
// mac_pkg: widths and sequencer state encoding shared by the MAC operand path.
package mac_pkg;
  localparam int DATA_W = 16;
  localparam int ACC_W = 34;
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, RESULT} state_t;
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: synchronous FIFO with wrap-bit pointers and show-ahead read data.
module operand_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers operand pairs and feeds one dot product at a time
// into an external MAC, then captures and holds the accumulated result.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic              busy,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);
  state_t state;
  logic [LEN_W-1:0] count;
  logic [2*DATA_W-1:0] head;
  logic full, empty, pop;
  assign pop = (state == CLEAR || state == ISSUE) && count != '0 && !empty;
  assign in_ready = !full;
  assign busy = state != IDLE;
  operand_fifo #(.DEPTH(FIFO_DEPTH), .W(2*DATA_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(in_valid),
    .pop(pop),
    .wr_data({in_a, in_b}),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  // Operands default to zero every cycle; only an actual pop puts data on the MAC.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      mac_a <= '0;
      mac_b <= '0;
      mac_clr <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
    end else begin
      mac_clr <= 1'b0;
      mac_a <= pop ? head[2*DATA_W-1:DATA_W] : '0;
      mac_b <= pop ? head[DATA_W-1:0] : '0;
      count <= count - LEN_W'(pop);
      case (state)
        IDLE:
          if (start) begin
            count <= vec_len;
            mac_clr <= 1'b1;
            state <= CLEAR;
          end
        CLEAR, ISSUE: state <= count == '0 ? DRAIN : ISSUE;
        DRAIN: begin
          res_data <= acc_in;
          res_valid <= 1'b1;
          state <= RESULT;
        end
        RESULT:
          if (res_ready) begin
            res_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed checks of the sequencer against a behavioural MAC.
module tb_mac_operand_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, start = 1'b0, busy, mac_clr, res_valid, res_ready = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, mac_a, mac_b;
  logic [7:0] vec_len = '0;
  logic [33:0] acc, res_data;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  // Behavioural MAC: synchronous clear, otherwise accumulate the product each edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else acc <= mac_clr ? 34'd0 : acc + 34'(mac_a) * 34'(mac_b);

  mac_operand_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start(start), .vec_len(vec_len), .busy(busy),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .acc_in(acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic kick(input logic [7:0] n);
    start = 1'b1;
    vec_len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    tick();

    // three-element dot product
    push(2, 3); push(4, 5); push(6, 7);
    kick(3);
    chk("a_clr", mac_clr, 1);
    chk("a_busy", busy, 1);
    tick(); chk("a_op1", {mac_a, mac_b}, {16'd2, 16'd3}); chk("a_clr_low", mac_clr, 0);
    tick(); chk("a_op2", {mac_a, mac_b}, {16'd4, 16'd5});
    tick(); chk("a_op3", {mac_a, mac_b}, {16'd6, 16'd7});
    tick(); chk("a_zero", {mac_a, mac_b}, 0); chk("a_rv_early", res_valid, 0);
    tick(); chk("a_rv", res_valid, 1); chk("a_res", res_data, 68);
    release_result();
    chk("a_rv_clr", res_valid, 0);
    chk("a_idle", busy, 0);

    // zero-length vector
    kick(0);
    chk("z_clr", mac_clr, 1);
    tick(); chk("z_zero", mac_a, 0); chk("z_rv_early", res_valid, 0);
    tick(); chk("z_rv", res_valid, 1); chk("z_res", res_data, 0);
    release_result();

    // bubbles while waiting on an empty buffer
    kick(2);
    tick(); chk("b_bub1", mac_a, 0);
    in_valid = 1'b1; in_a = 10; in_b = 10;
    tick(); in_valid = 1'b0; chk("b_bub2", mac_a, 0);
    tick(); chk("b_op1", {mac_a, mac_b}, {16'd10, 16'd10});
    tick(); chk("b_bub3", mac_a, 0);
    in_valid = 1'b1; in_a = 1; in_b = 1;
    tick(); in_valid = 1'b0; chk("b_bub4", mac_a, 0);
    tick(); chk("b_op2", {mac_a, mac_b}, {16'd1, 16'd1});
    tick(); chk("b_rv_early", res_valid, 0);
    tick(); chk("b_rv", res_valid, 1); chk("b_res", res_data, 101);

    // result held under backpressure, start ignored meanwhile
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      vec_len = 5;
      tick();
      chk("h_rv", res_valid, 1);
      chk("h_res", res_data, 101);
      chk("h_clr", mac_clr, 0);
    end
    start = 1'b0;
    release_result();
    chk("h_idle", busy, 0);
    tick();
    chk("h_ignored", busy, 0);

    // fill the buffer; ninth pair waits for the first pop
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_a = 16'(i); in_b = 16'(i);
      tick();
    end
    chk("f_full", in_ready, 0);
    in_a = 9; in_b = 9;
    tick(); chk("f_full_hold", in_ready, 0);
    kick(9);
    in_valid = 1'b1;
    tick(); chk("f_pop1", mac_a, 1); chk("f_ready", in_ready, 1);
    tick(); in_valid = 1'b0; chk("f_pop2", mac_a, 2);
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk("f_pop", {mac_a, mac_b}, {16'(k), 16'(k)});
    end
    tick(); chk("f_zero", mac_a, 0);
    tick(); chk("f_rv", res_valid, 1); chk("f_res", res_data, 285);
    tick(); chk("f_res_hold", res_data, 285);
    release_result();

    // reset mid-vector discards everything
    for (int i = 1; i <= 5; i++) push(16'(i), 16'(i));
    kick(5);
    tick(); tick();
    chk("r_pre", mac_a, 2);
    rst_n = 1'b0;
    #1;
    chk("r_mac_a", mac_a, 0);
    chk("r_busy", busy, 0);
    chk("r_in_ready", in_ready, 1);
    chk("r_res_data", res_data, 0);
    chk("r_res_valid", res_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("r_idle", busy, 0);
    kick(1);
    tick(); chk("r_empty", mac_a, 0);
    push(7, 7);
    chk("r_bub", mac_a, 0);
    tick(); chk("r_op", mac_a, 7);
    tick(); chk("r_rv_early", res_valid, 0);
    tick(); chk("r_rv", res_valid, 1); chk("r_res", res_data, 49);
    release_result();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mac_operand_sequencer.md
MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, operand-pair buffer depth (power of two, 2..64).
REQ-002 SHALL have parameter LEN_W, default 8, width of vector-length field.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a pair.
REQ-007 SHALL have port in_a  input  16  operand 1, unsigned.
REQ-008 SHALL have port in_b  input  16  operand 2, unsigned.
REQ-009 SHALL have port start  input  1  single-cycle request to begin one dot product.
REQ-010 SHALL have port vec_len  input  LEN_W  number of pairs; sampled with start.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port mac_a  output  16  registered operand 1 to MAC.
REQ-013 SHALL have port mac_b  output  16  registered operand 2 to MAC.
REQ-014 SHALL have port mac_clr  output  1  registered synchronous accumulator clear to MAC.
REQ-015 SHALL have port acc_in  input  34  accumulated sum returned from MAC.
REQ-016 SHALL have port res_valid  output  1  result available.
REQ-017 SHALL have port res_ready  input  1  consumer accepts result.
REQ-018 SHALL have port res_data  output  34  captured dot-product result.

Function
REQ-019 SHALL push a pair on every edge where in_valid && in_ready, in any state; in_ready = not full.
REQ-020 SHALL implement states IDLE, CLEAR, ISSUE, DRAIN, RESULT.
REQ-021 IDLE: start high SHALL latch vec_len into a remaining-count register, set mac_clr=1 for exactly one cycle, and enter CLEAR; start is ignored in all other states.
REQ-022 CLEAR: SHALL drive mac_clr=0 on the next edge; if count=0, go to DRAIN; otherwise go to ISSUE, popping the head pair into mac_a/mac_b on that same edge if the buffer is non-empty, else zeros.
REQ-023 ISSUE: each edge SHALL pop one pair into mac_a/mac_b and decrement count when non-empty; when empty, SHALL load zeros (bubble) and leave count unchanged.
REQ-024 After the pop that brings count to 0, the next edge SHALL load zeros into mac_a/mac_b and enter DRAIN.
REQ-025 DRAIN: next edge SHALL capture acc_in into res_data, set res_valid, and enter RESULT.
REQ-026 RESULT: res_data and res_valid SHALL hold stable until res_valid && res_ready; on that edge, clear res_valid and return to IDLE.
REQ-027 mac_a/mac_b SHALL be zero in every cycle that carries no issued pair.
REQ-028 With no bubbles, res_valid SHALL rise N+2 edges after the edge that samples start (N = vec_len, including N=0); each bubble adds one edge.
REQ-029 A pop and a push in the same cycle SHALL both complete; occupancy is unchanged.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, buffer empty, count 0, mac_a=mac_b=0, mac_clr=0, res_valid=0, res_data=0, busy=0, in_ready=1.
REQ-031 Reset asserted mid-operation SHALL abandon the vector and discard buffered pairs; no partial result is emitted.

Structure
REQ-032 SHALL take DATA_W=16, ACC_W=34 and the state enumeration from the shared package mac_pkg.
REQ-033 SHALL instantiate one sub-module, operand_fifo (synchronous FIFO, FIFO_DEPTH entries x 32 bits, full/empty flags).

Verification
REQ-034 Pre-fill (2,3),(4,5),(6,7), start with vec_len=3 -> one mac_clr pulse, three issued pairs, res_data=68, res_valid rising 5 edges after start.
REQ-035 start with vec_len=0 -> mac_clr pulse, no pops, res_data=0 after 2 edges.
REQ-036 start with vec_len=2 on an empty buffer, push (10,10) and (1,1) 3 cycles apart -> zeros issued during gaps, res_data=101, latency extended by the bubble count.
REQ-037 Push 9 pairs with no start -> in_ready low after the 8th push, 9th pair held until the first pop.
REQ-038 Hold res_ready low 5 cycles in RESULT, pulse start -> res_data stable, start ignored, IDLE entered on the res_ready edge.
REQ-039 Assert rst_n low during ISSUE with 3 pairs buffered -> all outputs zero immediately, buffer empty, no res_valid.
